// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch opcodes, FSM states, PC step.
// No logic; imported by the top and the condition evaluator.
// Backpressure: not applicable.
package branch_resolve_unit_pkg;

  localparam logic [2:0] BR_OP_BEQ  = 3'b000;
  localparam logic [2:0] BR_OP_BNE  = 3'b001;
  localparam logic [2:0] BR_OP_BLT  = 3'b010;
  localparam logic [2:0] BR_OP_BGT  = 3'b011;
  localparam logic [2:0] BR_OP_BLE  = 3'b100;
  localparam logic [2:0] BR_OP_BGE  = 3'b101;
  localparam logic [2:0] BR_OP_JMP  = 3'b110;
  localparam logic [2:0] BR_OP_NONE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/add_sub_32.sv
// Wrapping adder/subtractor; mode 0 adds, mode 1 subtracts, carry-out discarded.
// Latency: combinational.
// Backpressure: not applicable.
module add_sub_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_mode,
  output logic [W-1:0] o_y
);

  assign o_y = i_mode ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/branch_resolve_unit_cond_eval.sv
// Maps a branch opcode plus the lt/gt compare bits to a take decision.
// Latency: combinational.
// Backpressure: not applicable.
module br_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_lt,
  input  logic       i_gt,
  output logic       o_take
);

  // decode opcode into the taken condition
  always_comb begin
    o_take = 1'b0;
    case (i_op)
      BR_OP_BEQ:  o_take = ~i_lt & ~i_gt;
      BR_OP_BNE:  o_take = i_lt | i_gt;
      BR_OP_BLT:  o_take = i_lt;
      BR_OP_BGT:  o_take = i_gt;
      BR_OP_BLE:  o_take = ~i_gt;
      BR_OP_BGE:  o_take = ~i_lt;
      BR_OP_JMP:  o_take = 1'b1;
      BR_OP_NONE: o_take = 1'b0;
      default:    o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Latches a branch request, resolves taken/not-taken and next PC, hands it to fetch.
// Latency: accept edge -> CALC -> HOLD (out_valid) two edges later; one request per 3 cycles.
// Backpressure: result held in HOLD until out_ready; in_ready low outside IDLE; flush aborts.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        br_op,
  input  logic [DATA_W-1:0] lt_word,
  input  logic [DATA_W-1:0] gt_word,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] offset,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [DATA_W-1:0] target_pc,
  output logic              cond_err,
  output logic [CNT_W-1:0]  taken_count
);

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_handoff;
  logic                w_calc;

  logic [2:0]          r_op;
  logic                r_lt;
  logic                r_gt;
  logic                r_err_in;
  logic [DATA_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_off;

  logic                r_taken;
  logic [DATA_W-1:0]   r_target;
  logic                r_cond_err;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_take;
  logic                w_err_in;
  logic [DATA_W-1:0]   w_seq_pc;
  logic [DATA_W-1:0]   w_br_pc;
  logic [DATA_W-1:0]   w_off_sh;

  // Malformed compare words are flagged but the decision still uses bit0 only.
  assign w_err_in = (|lt_word[DATA_W-1:1]) | (|gt_word[DATA_W-1:1]) | (lt_word[0] & gt_word[0]);
  assign w_off_sh = {r_off[DATA_W-3:0], 2'b00};

  br_cond_eval u_cond (
    .i_op   (r_op),
    .i_lt   (r_lt),
    .i_gt   (r_gt),
    .o_take (w_take)
  );

  add_sub_32 #(.W(DATA_W)) u_add_seq (
    .i_a    (r_pc),
    .i_b    (DATA_W'(PC_STEP)),
    .i_mode (1'b0),
    .o_y    (w_seq_pc)
  );

  add_sub_32 #(.W(DATA_W)) u_add_br (
    .i_a    (w_seq_pc),
    .i_b    (w_off_sh),
    .i_mode (1'b0),
    .o_y    (w_br_pc)
  );

  // next-state and handshake strobes; flush overrides every transition
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_handoff = 1'b0;
    w_calc    = 1'b0;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_CALC;
        end
        ST_CALC: begin
          w_calc = 1'b1;
          w_next = ST_HOLD;
        end
        ST_HOLD: if (out_ready) begin
          w_handoff = 1'b1;
          w_next    = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // capture the request on acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= BR_OP_NONE;
      r_lt     <= 1'b0;
      r_gt     <= 1'b0;
      r_err_in <= 1'b0;
      r_pc     <= '0;
      r_off    <= '0;
    end else if (w_accept) begin
      r_op     <= br_op;
      r_lt     <= lt_word[0];
      r_gt     <= gt_word[0];
      r_err_in <= w_err_in;
      r_pc     <= pc;
      r_off    <= offset;
    end
  end

  // register the resolved result in CALC; it stays stable through HOLD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_taken    <= 1'b0;
      r_target   <= '0;
      r_cond_err <= 1'b0;
    end else if (w_calc) begin
      r_taken    <= w_take;
      r_target   <= w_take ? w_br_pc : w_seq_pc;
      r_cond_err <= r_err_in;
    end
  end

  // count taken results actually handed to fetch, sticking at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_handoff && r_taken && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign in_ready    = rst_n & (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_HOLD);
  assign taken       = r_taken;
  assign target_pc   = r_target;
  assign cond_err    = r_cond_err;
  assign taken_count = r_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  br_op;
  logic [31:0] lt_word;
  logic [31:0] gt_word;
  logic [31:0] pc;
  logic [31:0] offset;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] target_pc;
  logic        cond_err;
  logic [15:0] taken_count;

  // narrow-counter instance used to reach saturation in a few handoffs
  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_taken;
  logic [31:0] s_target_pc;
  logic        s_cond_err;
  logic [2:0]  s_taken_count;

  typedef struct {
    logic        tk;
    logic [31:0] tgt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .br_op(br_op), .lt_word(lt_word), .gt_word(gt_word), .pc(pc), .offset(offset),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .target_pc(target_pc), .cond_err(cond_err), .taken_count(taken_count)
  );

  branch_resolve_unit #(.DATA_W(32), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .br_op(br_op), .lt_word(lt_word), .gt_word(gt_word), .pc(pc), .offset(offset),
    .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .taken(s_taken),
    .target_pc(s_target_pc), .cond_err(s_cond_err), .taken_count(s_taken_count)
  );

  function automatic logic model_take(input logic [2:0] op, input logic l, input logic g);
    case (op)
      3'b000:  return !l && !g;
      3'b001:  return l || g;
      3'b010:  return l;
      3'b011:  return g;
      3'b100:  return !g;
      3'b101:  return !l;
      3'b110:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
  endfunction

  function automatic logic [2:0] exp_cnt3();
    return (m_cnt > 7) ? 3'd7 : 3'(m_cnt);
  endfunction

  // drive one request at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [31:0] l, input logic [31:0] g,
                       input logic [31:0] p, input logic [31:0] o);
    int   n;
    exp_t e;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_wait in_ready=%b required 1", in_ready);
    end
    br_op    = op;
    lt_word  = l;
    gt_word  = g;
    pc       = p;
    offset   = o;
    in_valid = 1'b1;
    e.tk  = model_take(op, l[0], g[0]);
    e.tgt = e.tk ? (p + 32'd4 + (o << 2)) : (p + 32'd4);
    e.err = (l[31:1] != 31'd0) || (g[31:1] != 31'd0) || (l[0] && g[0]);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // wait for a result, check it, hold out_ready low for 'stall' cycles, then hand off
  task automatic collect(input int stall);
    int   n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL collect_wait out_valid=%b required 1", out_valid);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL collect_queue size=0 required >0");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (taken !== e.tk) begin n_err++; $display("FAIL taken got=%b exp=%b", taken, e.tk); end
    n_cmp++;
    if (target_pc !== e.tgt) begin n_err++; $display("FAIL target_pc got=%h exp=%h", target_pc, e.tgt); end
    n_cmp++;
    if (cond_err !== e.err) begin n_err++; $display("FAIL cond_err got=%b exp=%b", cond_err, e.err); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL in_ready_hold got=%b exp=0", in_ready); end
    n_cmp++;
    if (s_out_valid !== 1'b1 || s_taken !== e.tk || s_target_pc !== e.tgt || s_cond_err !== e.err)
      begin n_err++; $display("FAIL narrow_result v=%b tk=%b tgt=%h err=%b exp tk=%b tgt=%h err=%b",
                              s_out_valid, s_taken, s_target_pc, s_cond_err, e.tk, e.tgt, e.err); end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || taken !== e.tk || target_pc !== e.tgt || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_stable v=%b tk=%b tgt=%h rdy=%b exp v=1 tk=%b tgt=%h rdy=0",
                 out_valid, taken, target_pc, in_ready, e.tk, e.tgt);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (e.tk) m_cnt++;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL handoff_valid got=%b exp=0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL handoff_ready got=%b exp=1", in_ready); end
    n_cmp++;
    if (taken_count !== exp_cnt16()) begin
      n_err++; $display("FAIL taken_count got=%h exp=%h", taken_count, exp_cnt16());
    end
    n_cmp++;
    if (s_taken_count !== exp_cnt3()) begin
      n_err++; $display("FAIL taken_count_sat got=%0d exp=%0d", s_taken_count, exp_cnt3());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0 || taken !== 1'b0 || target_pc !== 32'd0 || cond_err !== 1'b0 ||
        taken_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_outputs v=%b tk=%b tgt=%h err=%b cnt=%h exp all 0",
               out_valid, taken, target_pc, cond_err, taken_count);
    end
    rst_n = 1'b1;
    m_cnt = 0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_idle_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_blt_latency();
    issue(3'b010, 32'd1, 32'd0, 32'h100, 32'd3);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL calc_cycle v=%b rdy=%b exp v=0 rdy=0", out_valid, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
    collect(0);
  endtask

  task automatic test_stall();
    issue(3'b101, 32'd1, 32'd0, 32'h100, 32'd8);
    collect(5);
  endtask

  task automatic test_wrap_and_beq();
    issue(3'b110, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0);
    collect(0);
    issue(3'b000, 32'd0, 32'd0, 32'h40, 32'hFFFF_FFFF);
    collect(1);
    issue(3'b011, 32'd1, 32'd0, 32'h300, 32'd7);
    collect(0);
    issue(3'b111, 32'd0, 32'd1, 32'h500, 32'd1);
    collect(0);
  endtask

  task automatic test_cond_err();
    issue(3'b010, 32'h8000_0001, 32'd0, 32'h1000, 32'h10);
    collect(0);
    issue(3'b001, 32'd1, 32'd1, 32'h2000, 32'd2);
    collect(0);
    issue(3'b100, 32'd0, 32'h2, 32'h3000, 32'h4000_0001);
    collect(0);
  endtask

  task automatic test_back_to_back();
    issue(3'b110, 32'd0, 32'd0, 32'h800, 32'd1);
    collect(0);
    issue(3'b001, 32'd0, 32'd1, 32'h900, 32'd2);
    collect(0);
  endtask

  task automatic test_flush();
    issue(3'b110, 32'd0, 32'd0, 32'hA00, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(sb.pop_back());
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || taken_count !== exp_cnt16()) begin
      n_err++; $display("FAIL flush_calc v=%b rdy=%b cnt=%h exp v=0 rdy=1 cnt=%h",
                        out_valid, in_ready, taken_count, exp_cnt16());
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_calc_quiet got=%b exp=0", out_valid); end
    end
    issue(3'b110, 32'd0, 32'd0, 32'hB00, 32'd1);
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    void'(sb.pop_back());
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || taken_count !== exp_cnt16()) begin
      n_err++; $display("FAIL flush_hold v=%b rdy=%b cnt=%h exp v=0 rdy=1 cnt=%h",
                        out_valid, in_ready, taken_count, exp_cnt16());
    end
    in_valid = 1'b1;
    flush    = 1'b1;
    br_op    = 3'b110;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) begin
      issue(3'b110, 32'd0, 32'd0, 32'h100 + 32'(i * 16), 32'(i));
      collect(0);
    end
  endtask

  task automatic test_reset_in_hold();
    issue(3'b110, 32'd0, 32'd0, 32'h200, 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || taken !== 1'b0 || target_pc !== 32'd0 || cond_err !== 1'b0 ||
        taken_count !== 16'd0 || in_ready !== 1'b0 || s_taken_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_hold v=%b tk=%b tgt=%h err=%b cnt=%h rdy=%b exp all 0",
               out_valid, taken, target_pc, cond_err, taken_count, in_ready);
    end
    rst_n = 1'b1;
    m_cnt = 0;
    sb.delete();
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hold_recover rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    br_op     = 3'b111;
    lt_word   = 32'd0;
    gt_word   = 32'd0;
    pc        = 32'd0;
    offset    = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_blt_latency();
    test_stall();
    test_wrap_and_beq();
    test_cond_err();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
